// File: rtl/iomem_pkg.sv
// Shared definitions for PicoSoC iomem bus initiators and responders.
package iomem_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StRd,
    StRdGap,
    StWr,
    StWrGap,
    StFin
  } state_e;

  localparam logic [3:0]  WSTRB_NONE = 4'b0000;
  localparam logic [3:0]  WSTRB_FULL = 4'b1111;
  localparam logic [31:0] WORD_BYTES = 32'd4;

endpackage

// File: rtl/iomem_copy_master_if.sv
// PicoSoC iomem valid/ready bus; the initiator drives the request, the responder acknowledges.
interface iomem_copy_master_if;

  logic        valid;
  logic        ready;
  logic [3:0]  wstrb;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;

  modport master (
    output valid,
    output wstrb,
    output addr,
    output wdata,
    input  ready,
    input  rdata
  );

  modport slave (
    input  valid,
    input  wstrb,
    input  addr,
    input  wdata,
    output ready,
    output rdata
  );

endinterface

// File: rtl/iomem_timeout.sv
// Request watchdog: counts cycles a request waits for ready; expired marks the TIMEOUT-th wait.
module iomem_timeout #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic clk,
  input  logic resetn,
  input  logic clear,
  input  logic inc,
  output logic expired
);

  localparam int unsigned CntW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

  logic [CntW-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (inc) begin
      count_d = count_q + CntW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  // Flags the increment that makes the count reach TIMEOUT, so the caller can leave that same edge.
  assign expired = inc && !clear && (count_q == CntW'(TIMEOUT - 1));

endmodule

// File: rtl/iomem_copy_master.sv
// iomem bus initiator copying len words from src_addr to dst_addr as alternating read/write pairs.
module iomem_copy_master
  import iomem_pkg::*;
#(
  parameter int unsigned TIMEOUT = 255,
  parameter int unsigned LEN_W   = 16
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 start,
  input  logic [31:0]          src_addr,
  input  logic [31:0]          dst_addr,
  input  logic [LEN_W-1:0]     len,
  output logic                 busy,
  output logic                 done,
  output logic                 err,
  iomem_copy_master_if.master  iomem
);

  state_e state_q, state_d;

  logic [31:0]      src_q, src_d;
  logic [31:0]      dst_q, dst_d;
  logic [LEN_W-1:0] rem_q, rem_d;
  logic [31:0]      data_q, data_d;

  logic        valid_q, valid_d;
  logic [3:0]  wstrb_q, wstrb_d;
  logic [31:0] addr_q, addr_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        err_q, err_d;

  logic in_req;
  logic expired;

  assign in_req = (state_q == StRd) || (state_q == StWr);

  iomem_timeout #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout (
    .clk     (clk),
    .resetn  (resetn),
    .clear   (!in_req),
    .inc     (in_req && !iomem.ready),
    .expired (expired)
  );

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d = (len != '0) ? StRd : StFin;
        end
      end
      StRd: begin
        if (iomem.ready) begin
          state_d = StRdGap;
        end else if (expired) begin
          state_d = StFin;
        end
      end
      StRdGap: state_d = StWr;
      StWr: begin
        if (iomem.ready) begin
          state_d = StWrGap;
        end else if (expired) begin
          state_d = StFin;
        end
      end
      StWrGap: state_d = (rem_q != '0) ? StRd : StFin;
      StFin:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Outputs are computed from the next state so every bus/status signal leaves a flop.
  always_comb begin
    src_d  = src_q;
    dst_d  = dst_q;
    rem_d  = rem_q;
    data_d = data_q;
    if (state_q == StIdle && start && len != '0) begin
      src_d = src_addr;
      dst_d = dst_addr;
      rem_d = len;
    end
    if (state_q == StRd && iomem.ready) begin
      data_d = iomem.rdata;
    end
    if (state_q == StWr && iomem.ready) begin
      src_d = src_q + WORD_BYTES;
      dst_d = dst_q + WORD_BYTES;
      rem_d = rem_q - LEN_W'(1);
    end

    valid_d = (state_d == StRd) || (state_d == StWr);
    wstrb_d = (state_d == StWr) ? WSTRB_FULL : WSTRB_NONE;
    addr_d  = addr_q;
    if (state_d == StRd) begin
      addr_d = src_d;
    end else if (state_d == StWr) begin
      addr_d = dst_d;
    end
    busy_d = (state_d == StRd) || (state_d == StRdGap) ||
             (state_d == StWr) || (state_d == StWrGap);
    done_d = (state_d == StFin);
    err_d  = expired;
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      src_q   <= '0;
      dst_q   <= '0;
      rem_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      wstrb_q <= WSTRB_NONE;
      addr_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      src_q   <= src_d;
      dst_q   <= dst_d;
      rem_q   <= rem_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      wstrb_q <= wstrb_d;
      addr_q  <= addr_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign iomem.valid = valid_q;
  assign iomem.wstrb = wstrb_q;
  assign iomem.addr  = addr_q;
  assign iomem.wdata = data_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign err         = err_q;

endmodule

// File: tb/tb_iomem_copy_master.sv
// Directed bench for iomem_copy_master against a registered-ready memory responder.
module tb_iomem_copy_master;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        start = 1'b0;
  logic [31:0] src_addr = '0;
  logic [31:0] dst_addr = '0;
  logic [15:0] len = '0;
  logic        busy, done, err;

  int checks = 0;
  int errors = 0;

  iomem_copy_master_if bus ();

  iomem_copy_master #(
    .TIMEOUT (8),
    .LEN_W   (16)
  ) dut (
    .clk      (clk),
    .resetn   (resetn),
    .start    (start),
    .src_addr (src_addr),
    .dst_addr (dst_addr),
    .len      (len),
    .busy     (busy),
    .done     (done),
    .err      (err),
    .iomem    (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic [3:0]  wstrb;
    logic [31:0] wdata;
  } txn_t;

  txn_t        log_q[$];
  logic [31:0] mem [logic [31:0]];
  bit          never_ready = 1'b0;

  function automatic logic [31:0] mem_read(input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return {a[15:0], ~a[15:0]};
  endfunction

  // Responder like top: ready is registered and never given twice in a row.
  always @(posedge clk) begin
    if (!resetn) begin
      bus.ready <= 1'b0;
      bus.rdata <= '0;
    end else begin
      bus.ready <= 1'b0;
      if (bus.valid && !bus.ready && !never_ready) begin
        bus.ready <= 1'b1;
        bus.rdata <= mem_read(bus.addr);
      end
      if (bus.valid && bus.ready) begin
        log_q.push_back('{addr: bus.addr, wstrb: bus.wstrb, wdata: bus.wdata});
        if (bus.wstrb == 4'hF) mem[bus.addr] = bus.wdata;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic run_copy(input logic [31:0] s, input logic [31:0] d, input logic [15:0] n,
                          output int done_c, output bit err_c, output int vhi,
                          output int gmin, output int gmax, output bit busy_seen);
    int gap;
    bit seen_hi;
    log_q.delete();
    done_c = -1; err_c = 0; vhi = 0; gmin = 1000; gmax = 0; busy_seen = 0;
    gap = 0; seen_hi = 0;
    @(negedge clk);
    src_addr = s; dst_addr = d; len = n; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int c = 1; c <= 400; c++) begin
      if (bus.valid) begin
        vhi++;
        if (seen_hi && gap > 0) begin
          if (gap < gmin) gmin = gap;
          if (gap > gmax) gmax = gap;
        end
        gap = 0;
        seen_hi = 1;
      end else if (seen_hi) begin
        gap++;
      end
      if (busy) busy_seen = 1;
      if (done) begin
        done_c = c;
        err_c = err;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({busy, done, err, bus.valid} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_flags: got %b expected 0000", {busy, done, err, bus.valid});
    end
    checks++;
    if (bus.wstrb !== 4'h0) begin
      errors++; $display("FAIL reset_wstrb: got %h expected 0", bus.wstrb);
    end
    checks++;
    if (bus.addr !== 32'h0 || bus.wdata !== 32'h0) begin
      errors++; $display("FAIL reset_addr_wdata: got %h/%h expected 0/0", bus.addr, bus.wdata);
    end
    resetn = 1'b1;
    @(negedge clk);
    checks++;
    if ({busy, bus.valid} !== 2'b00) begin
      errors++; $display("FAIL idle_after_reset: got %b expected 00", {busy, bus.valid});
    end
  endtask

  task automatic test_single();
    int dc, vh, gmn, gmx; bit e, bs;
    mem[32'h0300_0000] = 32'hDEAD_BEEF;
    run_copy(32'h0300_0000, 32'h0300_0004, 16'd1, dc, e, vh, gmn, gmx, bs);
    checks++;
    if (dc != 7) begin errors++; $display("FAIL single_done_cycle: got %0d expected 7", dc); end
    checks++;
    if (e !== 1'b0) begin errors++; $display("FAIL single_err: got %b expected 0", e); end
    checks++;
    if (bs !== 1'b1) begin errors++; $display("FAIL single_busy: got %b expected 1", bs); end
    checks++;
    if (log_q.size() != 2) begin
      errors++; $display("FAIL single_txn_count: got %0d expected 2", log_q.size());
    end else begin
      checks++;
      if (log_q[0].addr !== 32'h0300_0000 || log_q[0].wstrb !== 4'h0) begin
        errors++;
        $display("FAIL single_read: got %h/%h expected 03000000/0", log_q[0].addr, log_q[0].wstrb);
      end
      checks++;
      if (log_q[1].addr !== 32'h0300_0004 || log_q[1].wstrb !== 4'hF) begin
        errors++;
        $display("FAIL single_write: got %h/%h expected 03000004/f", log_q[1].addr,
                 log_q[1].wstrb);
      end
      checks++;
      if (log_q[1].wdata !== 32'hDEAD_BEEF) begin
        errors++; $display("FAIL single_wdata: got %h expected deadbeef", log_q[1].wdata);
      end
    end
  endtask

  task automatic test_ramp();
    int dc, vh, gmn, gmx; bit e, bs;
    for (int i = 0; i < 4; i++) mem[32'h1000 + 32'(4 * i)] = 32'h1111_0000 + 32'(i);
    run_copy(32'h0000_1000, 32'h0000_2000, 16'd4, dc, e, vh, gmn, gmx, bs);
    checks++;
    if (dc != 25) begin errors++; $display("FAIL ramp_done_cycle: got %0d expected 25", dc); end
    checks++;
    if (gmn != 1 || gmx != 1) begin
      errors++; $display("FAIL ramp_gap: got min %0d max %0d expected 1/1", gmn, gmx);
    end
    checks++;
    if (log_q.size() != 8) begin
      errors++; $display("FAIL ramp_txn_count: got %0d expected 8", log_q.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (log_q[2*i].addr !== 32'h1000 + 32'(4 * i) || log_q[2*i].wstrb !== 4'h0) begin
          errors++; $display("FAIL ramp_read%0d: got %h expected %h", i, log_q[2*i].addr,
                             32'h1000 + 32'(4 * i));
        end
        checks++;
        if (log_q[2*i+1].addr !== 32'h2000 + 32'(4 * i) ||
            log_q[2*i+1].wdata !== 32'h1111_0000 + 32'(i)) begin
          errors++; $display("FAIL ramp_write%0d: got %h/%h expected %h/%h", i,
                             log_q[2*i+1].addr, log_q[2*i+1].wdata, 32'h2000 + 32'(4 * i),
                             32'h1111_0000 + 32'(i));
        end
      end
    end
  endtask

  task automatic test_zero_len();
    int dc, vh, gmn, gmx; bit e, bs;
    run_copy(32'h0000_3000, 32'h0000_4000, 16'd0, dc, e, vh, gmn, gmx, bs);
    checks++;
    if (dc != 1) begin errors++; $display("FAIL zero_done_cycle: got %0d expected 1", dc); end
    checks++;
    if (vh != 0) begin errors++; $display("FAIL zero_valid: got %0d cycles expected 0", vh); end
    checks++;
    if (bs !== 1'b0) begin errors++; $display("FAIL zero_busy: got %b expected 0", bs); end
  endtask

  task automatic test_timeout();
    int dc, vh, gmn, gmx; bit e, bs;
    never_ready = 1'b1;
    run_copy(32'h0000_4000, 32'h0000_5000, 16'd3, dc, e, vh, gmn, gmx, bs);
    checks++;
    if (vh != 8) begin errors++; $display("FAIL timeout_valid_cycles: got %0d expected 8", vh); end
    checks++;
    if (dc != 9) begin errors++; $display("FAIL timeout_done_cycle: got %0d expected 9", dc); end
    checks++;
    if (e !== 1'b1) begin errors++; $display("FAIL timeout_err: got %b expected 1", e); end
    @(negedge clk);
    checks++;
    if ({busy, done, err, bus.valid} !== 4'b0000) begin
      errors++;
      $display("FAIL timeout_idle: got %b expected 0000", {busy, done, err, bus.valid});
    end
    never_ready = 1'b0;
  endtask

  task automatic test_wrap();
    int dc, vh, gmn, gmx; bit e, bs;
    run_copy(32'hFFFF_FFFC, 32'h0000_0100, 16'd2, dc, e, vh, gmn, gmx, bs);
    checks++;
    if (dc != 13) begin errors++; $display("FAIL wrap_done_cycle: got %0d expected 13", dc); end
    checks++;
    if (log_q.size() != 4) begin
      errors++; $display("FAIL wrap_txn_count: got %0d expected 4", log_q.size());
    end else begin
      checks++;
      if (log_q[2].addr !== 32'h0000_0000) begin
        errors++; $display("FAIL wrap_read_addr: got %h expected 00000000", log_q[2].addr);
      end
      checks++;
      if (log_q[3].addr !== 32'h0000_0104) begin
        errors++; $display("FAIL wrap_write_addr: got %h expected 00000104", log_q[3].addr);
      end
    end
  endtask

  task automatic test_busy_reset();
    bit found, pulse;
    found = 0; pulse = 0;
    log_q.delete();
    @(negedge clk);
    src_addr = 32'h6000; dst_addr = 32'h7000; len = 16'd2; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    src_addr = 32'h9000; dst_addr = 32'h9800; len = 16'd1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int c = 0; c < 50; c++) begin
      if (bus.valid && bus.wstrb == 4'hF && log_q.size() >= 3) begin
        found = 1;
        break;
      end
      @(negedge clk);
    end
    checks++;
    if (!found) begin errors++; $display("FAIL busy_second_write: got none expected one"); end
    checks++;
    if (log_q.size() != 3) begin
      errors++; $display("FAIL busy_txn_count: got %0d expected 3", log_q.size());
    end else begin
      checks++;
      if (log_q[0].addr !== 32'h6000 || log_q[1].addr !== 32'h7000 ||
          log_q[2].addr !== 32'h6004) begin
        errors++; $display("FAIL busy_start_ignored: got %h %h %h expected 6000 7000 6004",
                           log_q[0].addr, log_q[1].addr, log_q[2].addr);
      end
    end
    resetn = 1'b0;
    @(negedge clk);
    checks++;
    if ({busy, done, err, bus.valid} !== 4'b0000) begin
      errors++;
      $display("FAIL midreset_flags: got %b expected 0000", {busy, done, err, bus.valid});
    end
    checks++;
    if (bus.addr !== 32'h0 || bus.wdata !== 32'h0 || bus.wstrb !== 4'h0) begin
      errors++; $display("FAIL midreset_bus: got %h/%h/%h expected 0/0/0", bus.addr, bus.wdata,
                         bus.wstrb);
    end
    repeat (2) begin
      @(negedge clk);
      if (done || err) pulse = 1;
    end
    resetn = 1'b1;
    repeat (10) begin
      @(negedge clk);
      if (done || err || busy || bus.valid) pulse = 1;
    end
    checks++;
    if (pulse) begin errors++; $display("FAIL midreset_quiet: got activity expected none"); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_ramp();
    test_zero_len();
    test_timeout();
    test_wrap();
    test_busy_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/iomem_copy_master.md
# iomem_copy_master

Bus-initiator block for the PicoSoC `iomem` valid/ready interface. It is the master side of the protocol that the GPIO/peripheral decoder in `top` answers as a responder. On a `start` pulse it copies `len` 32-bit words from `src_addr` to `dst_addr` using alternating single-word read and write transactions. It sits beside the SoC on a shared responder fabric and is used to fill the VGA text buffer and the GPIO/peripheral windows without CPU involvement.

## Interface
Parameters:
- `TIMEOUT`, default 255: cycles `iomem_valid` may stay high without `iomem_ready` before the transfer aborts.
- `LEN_W`, default 16: width of the word-count input.

Ports:
- `clk`, in, 1: single clock domain, same as `clk_bufg`.
- `resetn`, in, 1: synchronous, active-low reset.
- `start`, in, 1: one-cycle request. Sampled only in IDLE.
- `src_addr`, in, 32: source byte address, word aligned. Latched at start.
- `dst_addr`, in, 32: destination byte address, word aligned. Latched at start.
- `len`, in, LEN_W: number of words to copy. Latched at start.
- `busy`, out, 1: high from the cycle after an accepted start until the cycle `done` is high.
- `done`, out, 1: one-cycle pulse at the end of a transfer.
- `err`, out, 1: one-cycle pulse together with `done` when the transfer aborted on timeout.
- `iomem_valid`, out, 1: request strobe.
- `iomem_ready`, in, 1: responder acknowledge, a one-cycle pulse.
- `iomem_wstrb`, out, 4: `4'b1111` on writes, `4'b0000` on reads.
- `iomem_addr`, out, 32: transaction address.
- `iomem_wdata`, out, 32: write data, equal to the last word read.
- `iomem_rdata`, in, 32: read data, valid in the cycle `iomem_ready` is high.

## Operation
- States: IDLE, RD, RD_GAP, WR, WR_GAP, FIN.
- IDLE:
  - `start` with `len != 0`: latch inputs, go to RD.
  - `start` with `len == 0`: go to FIN with no bus traffic.
- RD: `iomem_valid=1`, `wstrb=0`, `addr=src`.
  - On `iomem_ready`: capture `iomem_rdata` into the data register and go to RD_GAP.
- RD_GAP: `iomem_valid=0` for exactly one cycle, then go to WR.
- WR: `iomem_valid=1`, `wstrb=4'hF`, `addr=dst`, `wdata` = captured word.
  - On `iomem_ready`: `src+=4`, `dst+=4`, `remaining-=1`, go to WR_GAP.
- WR_GAP: `iomem_valid=0` for one cycle. Then go to RD if `remaining != 0`, else to FIN.
- FIN: `done=1` for one cycle, then go to IDLE.
- Address arithmetic is 32-bit modulo. `0xFFFF_FFFC + 4` wraps to `0x0000_0000`.
- `addr`, `wdata` and `wstrb` are held stable for the whole time `iomem_valid` is high.
- Timeout:
  - The counter clears on entry to RD or WR and increments each cycle `valid` is high without `ready`.
  - When the count reaches TIMEOUT: drop `valid`, go to FIN, and assert `err` with `done`.
- `start` while `busy` is ignored. A `start` in FIN is also ignored.
- `iomem_ready` seen outside RD or WR is ignored.

## Timing
- Reset values: `busy=0`, `done=0`, `err=0`, `iomem_valid=0`, `iomem_wstrb=0`, `iomem_addr=0`, `iomem_wdata=0`. State returns to IDLE.
- Reset asserted mid-transfer takes effect on the next edge: `valid` drops immediately and no `done` is issued.
- Start at edge E0 puts `valid` high in the cycle after E0.
- With a responder that answers one cycle after seeing `valid` (registered ready, as in `top`):
  - Each transaction takes 3 cycles: valid, ready, gap.
  - Each word takes 6 cycles.
  - `done` comes 6·len+1 cycles after the start edge.
- The mandatory gap cycle ensures a registered responder never serves the same request twice.
- All outputs are registered. There is no combinational path from `iomem_ready` to any output.

## Structure
- Shared package `iomem_pkg` holds:
  - the state enum;
  - `WSTRB_NONE = 4'b0000` and `WSTRB_FULL = 4'b1111`;
  - `WORD_BYTES = 4`.
- The `top` responder and future bus initiators reuse the same package.
- One sub-module, `iomem_timeout`: a loadable up-counter with a `clear` input and an `expired` flag, parameterised by TIMEOUT. Everything else stays in one FSM module.

## Test plan
- `len=1`, `src=0x0300_0000`, `dst=0x0300_0004`, responder returns `0xDEADBEEF`:
  - one read then one write with `wdata=0xDEADBEEF`, `wstrb=F`;
  - `done` at cycle 7; `err=0`.
- `len=4`, src/dst ramp memory model:
  - 8 transactions, addresses step by 4, destination matches source;
  - `valid` low for exactly one cycle between transactions.
- `len=0`: `done` pulses one cycle after start; `iomem_valid` never rises; `busy` never rises.
- Responder that never asserts `ready`, `TIMEOUT=8`:
  - `valid` high for exactly 8 cycles;
  - `done` and `err` pulse together; block returns to IDLE.
- `src=0xFFFF_FFFC`, `len=2`: second read address is `0x0000_0000`.
- `start` pulsed while `busy`, and `resetn` low during WR:
  - the second start is ignored;
  - after reset all outputs are 0, with no `done` or `err`.
